// File: rtl/dbf_beam_sum.sv
// Beam summation: pipelined adder tree over all channel samples, then scale/saturate
// and frame the beam samples into receive lines of line_len samples.
module dbf_beam_sum #(
    parameter int NUM_CH = 64,
    parameter int CH_WD  = 32,
    parameter int OUT_WD = 24,
    parameter int SHIFT  = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [15:0]              line_len,
    input  logic [NUM_CH*CH_WD-1:0]  ch_din,
    input  logic [NUM_CH-1:0]        ch_valid,
    output logic [OUT_WD-1:0]        beam_dout,
    output logic                     beam_valid,
    output logic                     line_done,
    output logic                     sat_pulse,
    output logic                     vld_err,
    output logic                     busy
);

    localparam int TREE_D = $clog2(NUM_CH);
    localparam int PAD    = 1 << TREE_D;
    localparam int SUM_WD = CH_WD + TREE_D;

    localparam logic signed [SUM_WD-1:0] MAX_V = {{(SUM_WD-OUT_WD+1){1'b0}}, {(OUT_WD-1){1'b1}}};
    localparam logic signed [SUM_WD-1:0] MIN_V = {{(SUM_WD-OUT_WD+1){1'b1}}, {(OUT_WD-1){1'b0}}};
    localparam logic [OUT_WD-1:0]        OUT_MAX = {1'b0, {(OUT_WD-1){1'b1}}};
    localparam logic [OUT_WD-1:0]        OUT_MIN = {1'b1, {(OUT_WD-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t              state_d, state_q;
    logic                start_prev_d, start_prev_q;
    logic [15:0]         len_d, len_q;
    logic [15:0]         in_cnt_d, in_cnt_q;
    logic [15:0]         out_cnt_d, out_cnt_q;
    logic                vld_err_d, vld_err_q;

    logic                scl_vld_d, scl_vld_q;
    logic [OUT_WD-1:0]   scl_dout_d, scl_dout_q;
    logic                scl_sat_d, scl_sat_q;

    logic [OUT_WD-1:0]   beam_dout_d, beam_dout_q;
    logic                beam_valid_d, beam_valid_q;
    logic                line_done_d, line_done_q;
    logic                sat_pulse_d, sat_pulse_q;

    logic                start_rise;
    logic                flush;
    logic                accept;
    logic signed [SUM_WD-1:0] top_sum;
    logic signed [SUM_WD-1:0] shifted;
    logic                top_vld;

    assign start_rise = start && !start_prev_q;
    // Dropping start while a line is active kills every in-flight sample.
    assign flush      = (state_q != IDLE) && !start;
    assign accept     = (state_q == RUN) && start && (&ch_valid);

    for (genvar j = 0; j <= TREE_D; j++) begin : g_lvl
        localparam int W = CH_WD + j;
        localparam int N = PAD >> j;

        logic signed [W-1:0] sum_d [N];
        logic signed [W-1:0] sum_q [N];
        logic                vld_d, vld_q;

        if (j == 0) begin : g_in
            always_comb begin
                for (int unsigned k = 0; k < N; k++) begin
                    sum_d[k] = '0;
                end
                for (int unsigned k = 0; k < NUM_CH; k++) begin
                    sum_d[k] = ch_din[k*CH_WD +: CH_WD];
                end
                vld_d = accept;
            end
        end else begin : g_add
            always_comb begin
                for (int unsigned k = 0; k < N; k++) begin
                    sum_d[k] = W'(g_lvl[j-1].sum_q[2*k]) + W'(g_lvl[j-1].sum_q[2*k+1]);
                end
                vld_d = g_lvl[j-1].vld_q && !flush;
            end
        end

        always_ff @(posedge clk) begin
            if (vld_d) begin
                sum_q <= sum_d;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
            end else begin
                vld_q <= vld_d;
            end
        end
    end

    assign top_sum = g_lvl[TREE_D].sum_q[0];
    assign top_vld = g_lvl[TREE_D].vld_q;
    assign shifted = top_sum >>> SHIFT;

    always_comb begin
        scl_vld_d = top_vld && !flush;
        scl_sat_d = 1'b1;
        if (shifted > MAX_V) begin
            scl_dout_d = OUT_MAX;
        end else if (shifted < MIN_V) begin
            scl_dout_d = OUT_MIN;
        end else begin
            scl_dout_d = shifted[OUT_WD-1:0];
            scl_sat_d  = 1'b0;
        end
    end

    always_comb begin
        state_d      = state_q;
        start_prev_d = start;
        len_d        = len_q;
        in_cnt_d     = in_cnt_q;
        out_cnt_d    = out_cnt_q;
        vld_err_d    = vld_err_q;

        case (state_q)
            IDLE: begin
                if (start_rise && (line_len != '0)) begin
                    state_d   = RUN;
                    len_d     = line_len;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                    vld_err_d = 1'b0;
                end
            end
            RUN: begin
                if (!start) begin
                    state_d = IDLE;
                end else if (accept) begin
                    in_cnt_d = in_cnt_q + 16'd1;
                    if (in_cnt_q + 16'd1 == len_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!start || line_done_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if ((state_q == RUN) && (|ch_valid) && !(&ch_valid)) begin
            vld_err_d = 1'b1;
        end

        // Output stage sits one register after scaling so line framing lines up with the sample.
        beam_valid_d = scl_vld_q && !flush;
        beam_dout_d  = beam_valid_d ? scl_dout_q : beam_dout_q;
        sat_pulse_d  = beam_valid_d && scl_sat_q;
        line_done_d  = beam_valid_d && (out_cnt_q + 16'd1 == len_q);
        if (beam_valid_d) begin
            out_cnt_d = out_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (scl_vld_d) begin
            scl_dout_q <= scl_dout_d;
            scl_sat_q  <= scl_sat_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            start_prev_q <= 1'b0;
            len_q        <= '0;
            in_cnt_q     <= '0;
            out_cnt_q    <= '0;
            vld_err_q    <= 1'b0;
            scl_vld_q    <= 1'b0;
            beam_dout_q  <= '0;
            beam_valid_q <= 1'b0;
            line_done_q  <= 1'b0;
            sat_pulse_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= start_prev_d;
            len_q        <= len_d;
            in_cnt_q     <= in_cnt_d;
            out_cnt_q    <= out_cnt_d;
            vld_err_q    <= vld_err_d;
            scl_vld_q    <= scl_vld_d;
            beam_dout_q  <= beam_dout_d;
            beam_valid_q <= beam_valid_d;
            line_done_q  <= line_done_d;
            sat_pulse_q  <= sat_pulse_d;
        end
    end

    assign beam_dout  = beam_dout_q;
    assign beam_valid = beam_valid_q;
    assign line_done  = line_done_q;
    assign sat_pulse  = sat_pulse_q;
    assign vld_err    = vld_err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_dbf_beam_sum.sv
// Scoreboard bench for dbf_beam_sum: the driver pushes reference beam samples,
// a negedge monitor pops and compares whenever beam_valid is presented.
module tb_dbf_beam_sum;

    localparam int NUM_CH = 64;
    localparam int CH_WD  = 32;
    localparam int OUT_WD = 24;
    localparam int SHIFT  = 6;
    localparam int LAT    = 8;
    localparam longint OMAX = 64'sd8388607;
    localparam longint OMIN = -64'sd8388608;

    typedef logic [NUM_CH*CH_WD-1:0] vec_t;
    typedef struct {
        longint dout;
        bit     sat;
        bit     done;
        longint cyc;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     start;
    logic [15:0]              line_len;
    vec_t                     ch_din;
    logic [NUM_CH-1:0]        ch_valid;
    logic signed [OUT_WD-1:0] beam_dout;
    logic                     beam_valid;
    logic                     line_done;
    logic                     sat_pulse;
    logic                     vld_err;
    logic                     busy;

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    exp_t   exp_q[$];
    exp_t   mon_e;

    bit     m_run = 1'b0;
    bit     m_err = 1'b0;
    int     m_cnt = 0;
    int     m_len = 0;

    dbf_beam_sum #(
        .NUM_CH (NUM_CH),
        .CH_WD  (CH_WD),
        .OUT_WD (OUT_WD),
        .SHIFT  (SHIFT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .line_len   (line_len),
        .ch_din     (ch_din),
        .ch_valid   (ch_valid),
        .beam_dout  (beam_dout),
        .beam_valid (beam_valid),
        .line_done  (line_done),
        .sat_pulse  (sat_pulse),
        .vld_err    (vld_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void ref_beam(input vec_t d, output longint val, output bit sat);
        longint s;
        s = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            s += longint'($signed(d[i*CH_WD +: CH_WD]));
        end
        s = s >>> SHIFT;
        sat = 1'b1;
        if (s > OMAX)      val = OMAX;
        else if (s < OMIN) val = OMIN;
        else begin
            val = s;
            sat = 1'b0;
        end
    endfunction

    function automatic vec_t uniform_vec(input logic [CH_WD-1:0] v);
        vec_t d;
        for (int i = 0; i < NUM_CH; i++) d[i*CH_WD +: CH_WD] = v;
        return d;
    endfunction

    function automatic vec_t rand_vec();
        vec_t d;
        int unsigned mode;
        mode = $urandom_range(0, 2);
        for (int i = 0; i < NUM_CH; i++) begin
            if (mode == 0)      d[i*CH_WD +: CH_WD] = CH_WD'(int'($urandom_range(0, 2000000)) - 1000000);
            else if (mode == 1) d[i*CH_WD +: CH_WD] = CH_WD'(int'($urandom_range(0, 32'h1000_0000)) - 32'sh0800_0000);
            else                d[i*CH_WD +: CH_WD] = $urandom;
        end
        return d;
    endfunction

    always @(negedge clk) begin
        if (beam_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beam_valid: got beam_dout=%0d, expected no beam sample (cycle %0d)", beam_dout, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("beam_dout", beam_dout, mon_e.dout);
                check("sat_pulse", sat_pulse, mon_e.sat);
                check("line_done", line_done, mon_e.done);
                check("beam_cycle", cyc, mon_e.cyc);
            end
        end else begin
            check("flags_without_valid", {line_done, sat_pulse}, 0);
        end
    end

    // Issues one input slot; the accept decision comes from the line model, not the DUT.
    task automatic drive(input vec_t d, input logic [NUM_CH-1:0] v);
        exp_t e;
        @(posedge clk); #1;
        ch_din   = d;
        ch_valid = v;
        if (m_run) begin
            if (&v) begin
                ref_beam(d, e.dout, e.sat);
                e.done = (m_cnt + 1 == m_len);
                e.cyc  = cyc + 1 + LAT;
                exp_q.push_back(e);
                m_cnt++;
                if (m_cnt == m_len) m_run = 1'b0;
            end else if (|v) begin
                m_err = 1'b1;
            end
        end
    endtask

    task automatic start_line(input int len);
        @(posedge clk); #1;
        start    = 1'b0;
        ch_valid = '0;
        @(posedge clk); #1;
        start    = 1'b1;
        line_len = 16'(len);
        @(posedge clk); #1;
        check("busy_after_start", busy, (len != 0));
        if (len != 0) begin
            check("vld_err_cleared", vld_err, 0);
            m_run = 1'b1;
            m_cnt = 0;
            m_len = len;
            m_err = 1'b0;
        end
    endtask

    task automatic wait_drain();
        @(posedge clk); #1;
        ch_valid = '0;
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        check("drain_pending", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        check("busy_idle", busy, 0);
        check("vld_err_line", vld_err, m_err);
    endtask

    task automatic abort_line();
        @(posedge clk); #1;
        start    = 1'b0;
        ch_valid = '0;
        m_run    = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
        check("busy_after_abort", busy, 0);
        repeat (20) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no end of test, expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        vec_t mixed;
        logic [NUM_CH-1:0] part;
        bit found;

        rst_n    = 1'b0;
        start    = 1'b0;
        line_len = '0;
        ch_din   = '0;
        ch_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_beam_dout", beam_dout, 0);
        check("rst_beam_valid", beam_valid, 0);
        check("rst_line_done", line_done, 0);
        check("rst_sat_pulse", sat_pulse, 0);
        check("rst_vld_err", vld_err, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;

        // Nominal line: 64 x 1000 -> 1000, done with the 4th, busy drops a cycle later.
        start_line(4);
        repeat (4) drive(uniform_vec(32'd1000), '1);
        @(posedge clk); #1;
        ch_valid = '0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (line_done === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        check("line_done_seen", found, 1);
        check("busy_with_done", busy, 1);
        @(negedge clk);
        check("busy_after_done", busy, 0);
        wait_drain();

        for (int i = 0; i < NUM_CH; i++) mixed[i*CH_WD +: CH_WD] = (i % 2 == 0) ? 32'd500 : -32'sd300;
        start_line(2);
        drive(mixed, '1);
        drive(mixed, '1);
        wait_drain();

        start_line(2);
        drive(uniform_vec(32'h7FFF_FFFF), '1);
        drive(uniform_vec(32'h8000_0000), '1);
        wait_drain();

        // Partial valid is dropped and latches vld_err; the line still completes.
        part    = '1;
        part[5] = 1'b0;
        start_line(3);
        drive(uniform_vec(32'd64), '1);
        drive(uniform_vec(32'd99999), part);
        drive(uniform_vec(-32'sd128), '1);
        check("vld_err_set", vld_err, 1);
        drive(uniform_vec(32'd7), '1);
        wait_drain();

        start_line(0);

        start_line(10);
        drive(uniform_vec(32'd1000), '1);
        drive(uniform_vec(32'd2000), '1);
        abort_line();
        start_line(3);
        repeat (3) drive(rand_vec(), '1);
        wait_drain();

        // Reset while the line is draining: in-flight samples must never surface.
        start_line(4);
        repeat (4) drive(uniform_vec(32'd321), '1);
        @(posedge clk); #1;
        rst_n    = 1'b0;
        start    = 1'b0;
        ch_valid = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        m_run = 1'b0;
        m_err = 1'b0;
        check("rstd_beam_dout", beam_dout, 0);
        check("rstd_beam_valid", beam_valid, 0);
        check("rstd_line_done", line_done, 0);
        check("rstd_busy", busy, 0);
        repeat (20) @(posedge clk);

        for (int ln = 0; ln < 8; ln++) begin
            start_line(int'($urandom_range(1, 8)));
            for (int n = 0; n < 200 && m_run; n++) begin
                int unsigned r;
                logic [NUM_CH-1:0] v;
                r = $urandom_range(0, 9);
                v = '1;
                if (r == 7)      v = '0;
                else if (r > 7)  v[$urandom_range(0, NUM_CH-1)] = 1'b0;
                drive(rand_vec(), v);
            end
            wait_drain();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
